div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 162 ++++++++++++++++
 tb/tb_div_iter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, with
// signed/unsigned operation, divide-by-zero flag and in-flight cancel.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 dbz_o
);

    typedef enum logic [2:0] {IDLE, ZERO, RUN, FIX, DONE} state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sdiv_q, sdiv_d;
    logic                 neg1_q, neg1_d;
    logic                 neg2_q, neg2_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 dbz_q, dbz_d;

    logic                 neg1_in, neg2_in;
    logic [WIDTH:0]       shift_w, diff_w;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sdiv_d   = sdiv_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        result_d = result_q;
        ready_d  = ready_q;
        dbz_d    = dbz_q;

        neg1_in = signed_div_i & opdata1_i[WIDTH-1];
        neg2_in = signed_div_i & opdata2_i[WIDTH-1];

        // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
        shift_w = {rem_q, quo_q[WIDTH-1]};
        diff_w  = shift_w - {1'b0, dsr_q};

        quo_fix = (sdiv_q && (neg1_q ^ neg2_q)) ? -quo_q : quo_q;
        rem_fix = (sdiv_q && neg1_q) ? -rem_q : rem_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    sdiv_d = signed_div_i;
                    neg1_d = neg1_in;
                    neg2_d = neg2_in;
                    dvd_d  = opdata1_i;
                    quo_d  = neg1_in ? -opdata1_i : opdata1_i;
                    dsr_d  = neg2_in ? -opdata2_i : opdata2_i;
                    rem_d  = '0;
                    cnt_d  = '0;
                    state_d = (opdata2_i == '0) ? ZERO : RUN;
                end
            end
            ZERO: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = {dvd_q, {WIDTH{1'b1}}};
                    ready_d  = 1'b1;
                    dbz_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            RUN: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    if (!diff_w[WIDTH]) begin
                        rem_d = diff_w[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shift_w[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    dbz_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sdiv_q   <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            dvd_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sdiv_q   <= sdiv_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dsr_q    <= dsr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign dbz_o    = dbz_q;
    assign busy_o   = (state_q == ZERO) || (state_q == RUN) || (state_q == FIX);

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus random
// operands against an arithmetic reference, at WIDTH=32 and WIDTH=8.
module tb_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        sdiv, start, annul;
    logic [31:0] op1, op2;
    logic [63:0] res;
    logic        ready, busy, dbz;

    logic        sdiv8, start8, annul8;
    logic [7:0]  op1_8, op2_8;
    logic [15:0] res8;
    logic        ready8, busy8, dbz8;

    div_iter #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .signed_div_i(sdiv),
        .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
        .result_o(res), .ready_o(ready), .busy_o(busy), .dbz_o(dbz)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .signed_div_i(sdiv8),
        .opdata1_i(op1_8), .opdata2_i(op2_8), .start_i(start8), .annul_i(annul8),
        .result_o(res8), .ready_o(ready8), .busy_o(busy8), .dbz_o(dbz8)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient} for a w-bit divide using plain longint arithmetic
    // (truncating division, remainder takes the dividend's sign).
    function automatic logic [63:0] model(input int w, input bit s, input logic [63:0] a, input logic [63:0] b);
        logic [63:0]        mask;
        logic signed [63:0] ta, tb;
        longint             sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        if (b == 64'd0) return (a << w) | mask;
        if (s) begin
            ta = a << (64 - w);
            tb = b << (64 - w);
            sa = ta >>> (64 - w);
            sb = tb >>> (64 - w);
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return ((64'(r) & mask) << w) | (64'(q) & mask);
    endfunction

    task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int          lat;
        int          exp_lat;
        exp     = model(32, s, 64'(a), 64'(b));
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        sdiv = s; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        check({tag, " busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!ready && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4) begin
                op1 = $urandom; op2 = $urandom; sdiv = ~sdiv;
            end
        end
        check({tag, " lat"}, 64'(lat), 64'(exp_lat));
        check({tag, " res"}, res, exp);
        check({tag, " dbz"}, 64'(dbz), 64'(b == 32'd0));
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1;
        check({tag, " hold"}, {res[62:0], ready}, {exp[62:0], 1'b1});
        @(negedge clk); annul = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check({tag, " clr"}, {res[60:0], ready, dbz, busy}, 64'd0);
    endtask

    task automatic do_op8(input bit s, input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [63:0] exp;
        int          lat;
        exp = model(8, s, 64'(a), 64'(b));
        @(negedge clk);
        sdiv8 = s; op1_8 = a; op2_8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ready8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " lat"}, 64'(lat), (b == 8'd0) ? 64'd1 : 64'd9);
        check({tag, " res"}, 64'(res8), exp);
        check({tag, " dbz"}, 64'(dbz8), 64'(b == 8'd0));
        @(negedge clk); start8 = 1'b0;
        @(posedge clk); #1;
        check({tag, " clr"}, {45'd0, res8, ready8, dbz8, busy8}, 64'd0);
    endtask

    initial begin
        int          seen;
        bit          s;
        logic [31:0] a, b;
        rstn = 1'b0; sdiv = 1'b0; start = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
        sdiv8 = 1'b0; start8 = 1'b0; annul8 = 1'b0; op1_8 = '0; op2_8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {res[59:0], ready, busy, dbz}, 63'd0);
        @(negedge clk); rstn = 1'b1;

        do_op(1'b0, 32'd100, 32'd7, "u100/7");
        do_op(1'b1, -32'sd7, 32'd2, "s-7/2");
        do_op(1'b1, 32'd7, -32'sd2, "s7/-2");
        do_op(1'b0, 32'd5, 32'd0, "u5/0");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "smin/-1");
        do_op(1'b1, 32'hFFFF_FFF0, 32'd0, "s-16/0");

        // cancel at RUN cycle 10
        @(negedge clk); sdiv = 1'b0; op1 = 32'd1234; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("annul pre busy", 64'(busy), 64'd1);
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1;
        check("annul post", {res[60:0], busy, ready, dbz}, 64'd0);
        @(negedge clk); annul = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready || busy) seen = 1;
        end
        check("annul quiet", 64'(seen), 64'd0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h10, "uffff/16");

        // start with annul in IDLE must not accept
        @(negedge clk); op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        check("idle annul", {63'd0, busy}, 64'd0);
        @(negedge clk); start = 1'b0; annul = 1'b0;

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            do_op(s, a, b, $sformatf("rnd%0d", i));
        end

        // asynchronous reset in the middle of RUN
        @(negedge clk); sdiv = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        check("mid busy", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        check("async rst", {res[60:0], busy, ready, dbz}, 64'd0);
        start = 1'b0;
        @(negedge clk); rstn = 1'b1;
        do_op(1'b1, -32'sd100, 32'd7, "post rst");

        do_op8(1'b0, 8'd200, 8'd3, "w8 200/3");
        do_op8(1'b1, 8'h80, 8'hFF, "w8 smin/-1");
        do_op8(1'b0, 8'd17, 8'd0, "w8 17/0");
        for (int i = 0; i < 10; i++) begin
            do_op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(1, 255)),
                   $sformatf("w8 rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
